writeback_buffer: RTL and testbench

- In-order write-back stage that produces the register bank's write port (write data, write address, write enable).
- Sits between EX/MEM and the register bank. Accepts completed instructions from EX; holds loads until memory returns data; retires strictly in program order.
- Provides a combinational pending-write check on the two source registers so decode can stall on RAW hazards.

---
 rtl/writeback_buffer.sv | 129 ++++++++++++
 tb/tb_writeback_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : writeback_buffer
// Description : In-order write-back queue between EX/MEM and the register
//               bank; holds loads until memory data returns, exposes RAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    iss_valid,
    output logic                    iss_ready,
    input  logic [REG_ADDR_W-1:0]   iss_rd,
    input  logic                    iss_regwrite,
    input  logic                    iss_is_load,
    input  logic [DATA_W-1:0]       iss_alu_result,
    input  logic                    mem_rsp_valid,
    output logic                    mem_rsp_ready,
    input  logic [DATA_W-1:0]       mem_rsp_data,
    input  logic [REG_ADDR_W-1:0]   rs1,
    input  logic [REG_ADDR_W-1:0]   rs2,
    output logic                    hazard_rs1,
    output logic                    hazard_rs2,
    output logic                    wb_en,
    output logic [REG_ADDR_W-1:0]   wb_rd,
    output logic [DATA_W-1:0]       wb_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [DEPTH-1:0]       r_valid;
    logic [REG_ADDR_W-1:0]  r_rd       [DEPTH];
    logic                   r_regwrite [DEPTH];
    logic                   r_is_load  [DEPTH];
    logic [DATA_W-1:0]      r_data     [DEPTH];

    logic                   r_wb_en;
    logic [REG_ADDR_W-1:0]  r_wb_rd;
    logic [DATA_W-1:0]      r_wb_data;

    logic w_head_valid;
    logic w_head_load;
    logic w_issue;
    logic w_retire;
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_head_valid  = r_valid[r_rd_ptr];
    assign w_head_load   = r_is_load[r_rd_ptr];
    assign iss_ready     = (r_count != c_FULL);
    assign mem_rsp_ready = w_head_valid & w_head_load;
    assign w_issue       = iss_valid & iss_ready;
    // A load head retires only in the cycle its response is handed over.
    assign w_retire      = w_head_valid & (~w_head_load | mem_rsp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_valid   <= '0;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_en <= 1'b0;
            if (w_retire) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_PTR_W'(1);
                r_wb_en           <= r_regwrite[r_rd_ptr] & (r_rd[r_rd_ptr] != '0);
                r_wb_rd           <= r_rd[r_rd_ptr];
                r_wb_data         <= w_head_load ? mem_rsp_data : r_data[r_rd_ptr];
            end
            if (w_issue) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
            end
            case ({w_issue, w_retire})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through r_valid.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_rd[r_wr_ptr]       <= iss_rd;
            r_regwrite[r_wr_ptr] <= iss_regwrite;
            r_is_load[r_wr_ptr]  <= iss_is_load;
            r_data[r_wr_ptr]     <= iss_alu_result;
        end
    end

    always_comb begin
        w_hit_rs1 = 1'b0;
        w_hit_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_regwrite[i]) begin
                if (r_rd[i] == rs1) w_hit_rs1 = 1'b1;
                if (r_rd[i] == rs2) w_hit_rs2 = 1'b1;
            end
        end
        // The bank commits one edge after wb_en, so the wb stage is still pending.
        if (r_wb_en && (r_wb_rd == rs1)) w_hit_rs1 = 1'b1;
        if (r_wb_en && (r_wb_rd == rs2)) w_hit_rs2 = 1'b1;
    end

    assign hazard_rs1 = (rs1 != '0) & w_hit_rs1;
    assign hazard_rs2 = (rs2 != '0) & w_hit_rs2;

    assign wb_en   = r_wb_en;
    assign wb_rd   = r_wb_rd;
    assign wb_data = r_wb_data;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_buffer
// Description : Directed table-driven bench plus load/full/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_buffer;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic        iss_regwrite;
    logic        iss_is_load;
    logic [63:0] iss_alu_result;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [63:0] mem_rsp_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_buffer #(.DEPTH(4), .DATA_W(64), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .iss_regwrite(iss_regwrite), .iss_is_load(iss_is_load),
        .iss_alu_result(iss_alu_result),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data),
        .rs1(rs1), .rs2(rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic        rw;
        logic [63:0] alu;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_rdy;
        logic        e_h1;
        logic        e_h2;
        logic        e_wen;
        logic [4:0]  e_wrd;
        logic [63:0] e_wdata;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic iv, logic [4:0] rd, logic rw, logic [63:0] alu,
                                logic [4:0] r1, logic [4:0] r2, logic e_rdy,
                                logic e_h1, logic e_h2, logic e_wen, logic [4:0] e_wrd,
                                logic [63:0] e_wdata, logic [2:0] e_cnt);
        vec_t v;
        v.iv = iv; v.rd = rd; v.rw = rw; v.alu = alu; v.r1 = r1; v.r2 = r2;
        v.e_rdy = e_rdy; v.e_h1 = e_h1; v.e_h2 = e_h2; v.e_wen = e_wen;
        v.e_wrd = e_wrd; v.e_wdata = e_wdata; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [4:0] rd, input logic rw, input logic ld,
                         input logic [63:0] alu, input logic mv, input logic [63:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        iss_valid = iv; iss_rd = rd; iss_regwrite = rw; iss_is_load = ld;
        iss_alu_result = alu; mem_rsp_valid = mv; mem_rsp_data = md; rs1 = r1; rs2 = r2;
        #1;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [4:0] rd,
                            input logic [63:0] data, input logic [2:0] cnt);
        check({tag, " wb_en"}, 64'(wb_en), 64'(en));
        check({tag, " wb_rd"}, 64'(wb_rd), 64'(rd));
        check({tag, " wb_data"}, wb_data, data);
        check({tag, " count"}, 64'(count), 64'(cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // single ALU op, hazard through wb stage
        vt.push_back(mk(1, 5, 1, 64'h1234, 5, 0, 1, 0, 0, 0, 0, 64'h0, 1));
        vt.push_back(mk(0, 0, 0, 64'h0,    5, 5, 1, 1, 1, 1, 5, 64'h1234, 0));
        vt.push_back(mk(0, 0, 0, 64'h0,    5, 6, 1, 1, 0, 0, 5, 64'h1234, 0));
        vt.push_back(mk(0, 0, 0, 64'h0,    5, 0, 1, 0, 0, 0, 5, 64'h1234, 0));
        // x0 destination and regwrite=0 both retire silently
        vt.push_back(mk(1, 0, 1, 64'hFF,   0, 9, 1, 0, 0, 0, 5, 64'h1234, 1));
        vt.push_back(mk(1, 9, 0, 64'h99,   0, 9, 1, 0, 0, 0, 0, 64'hFF, 1));
        vt.push_back(mk(0, 0, 0, 64'h0,    0, 9, 1, 0, 0, 0, 9, 64'h99, 0));
        // back-to-back stream: count settles at 1
        for (int i = 0; i < 10; i++) begin
            if (i == 0)
                vt.push_back(mk(1, 5'(10 + i), 1, 64'h100 + 64'(i), 0, 20, 1, 0, 0,
                                0, 9, 64'h99, 1));
            else
                vt.push_back(mk(1, 5'(10 + i), 1, 64'h100 + 64'(i), 5'(9 + i), 20, 1, 1, 0,
                                1, 5'(9 + i), 64'h100 + 64'(i - 1), 1));
        end
        vt.push_back(mk(0, 0, 0, 64'h0, 19, 20, 1, 1, 0, 1, 19, 64'h109, 0));
        vt.push_back(mk(0, 0, 0, 64'h0, 19, 20, 1, 1, 0, 0, 19, 64'h109, 0));

        tick();
        tick();
        check_wb("reset", 0, 0, 64'h0, 0);
        check("reset iss_ready", 64'(iss_ready), 64'd1);
        check("reset mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
        rst_n = 1'b1;
        tick();

        foreach (vt[k]) begin
            drive(vt[k].iv, vt[k].rd, vt[k].rw, 1'b0, vt[k].alu, 1'b0, 64'h0, vt[k].r1, vt[k].r2);
            check($sformatf("vec%0d iss_ready", k), 64'(iss_ready), 64'(vt[k].e_rdy));
            check($sformatf("vec%0d mem_rsp_ready", k), 64'(mem_rsp_ready), 64'd0);
            check($sformatf("vec%0d hazard_rs1", k), 64'(hazard_rs1), 64'(vt[k].e_h1));
            check($sformatf("vec%0d hazard_rs2", k), 64'(hazard_rs2), 64'(vt[k].e_h2));
            tick();
            check_wb($sformatf("vec%0d", k), vt[k].e_wen, vt[k].e_wrd, vt[k].e_wdata, vt[k].e_cnt);
        end

        // load blocks a younger ALU op until its response arrives
        drive(1, 7, 1, 1, 64'h5555, 0, 0, 0, 0);
        tick();
        check_wb("ld issue", 0, 19, 64'h109, 1);
        drive(1, 8, 1, 0, 64'hAA, 0, 0, 7, 8);
        check("ld mem_rsp_ready", 64'(mem_rsp_ready), 64'd1);
        check("ld hazard_rs1", 64'(hazard_rs1), 64'd1);
        tick();
        check_wb("alu behind ld", 0, 19, 64'h109, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ld wait%0d mem_rsp_ready", i), 64'(mem_rsp_ready), 64'd1);
            tick();
            check_wb($sformatf("ld wait%0d", i), 0, 19, 64'h109, 2);
        end
        drive(0, 0, 0, 0, 0, 1, 64'hDEAD, 0, 0);
        tick();
        check_wb("ld retire", 1, 7, 64'hDEAD, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("alu head mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
        tick();
        check_wb("alu after ld", 1, 8, 64'hAA, 0);
        tick();
        check_wb("ld idle", 0, 8, 64'hAA, 0);

        // fill to DEPTH behind a load, then drain with pointer wrap
        drive(1, 20, 1, 1, 64'h0, 0, 0, 0, 0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive(1, 5'(k), 1, 0, 64'h11 * 64'(k), 0, 0, 0, 0);
            tick();
        end
        check_wb("full", 0, 8, 64'hAA, 4);
        drive(1, 4, 1, 0, 64'h44, 0, 0, 3, 4);
        check("full iss_ready", 64'(iss_ready), 64'd0);
        check("full hazard_rs1", 64'(hazard_rs1), 64'd1);
        check("full hazard_rs2", 64'(hazard_rs2), 64'd0);
        tick();
        check_wb("full blocked", 0, 8, 64'hAA, 4);
        drive(1, 4, 1, 0, 64'h44, 1, 64'hBEEF, 0, 0);
        check("full+retire iss_ready", 64'(iss_ready), 64'd0);
        tick();
        check_wb("full ld retire", 1, 20, 64'hBEEF, 3);
        drive(1, 4, 1, 0, 64'h44, 0, 0, 0, 0);
        check("count3 iss_ready", 64'(iss_ready), 64'd1);
        tick();
        check_wb("issue+retire rd1", 1, 1, 64'h11, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check_wb($sformatf("drain rd%0d", k), 1, 5'(k), 64'h11 * 64'(k), 3'(4 - k));
        end
        tick();
        check_wb("drain idle", 0, 4, 64'h44, 0);

        // asynchronous reset with a load at the head
        drive(1, 21, 1, 1, 64'h0, 0, 0, 0, 0);
        tick();
        drive(1, 22, 1, 0, 64'h22, 0, 0, 0, 0);
        tick();
        drive(1, 23, 1, 0, 64'h23, 0, 0, 22, 0);
        tick();
        check_wb("pre-reset", 0, 4, 64'h44, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 22, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_wb("mid reset", 0, 0, 64'h0, 0);
        check("mid reset mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
        check("mid reset hazard_rs1", 64'(hazard_rs1), 64'd0);
        drive(0, 0, 0, 0, 0, 1, 64'hCAFE, 22, 0);
        tick();
        check_wb("reset held", 0, 0, 64'h0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_wb("after reset", 0, 0, 64'h0, 0);
        check("after reset iss_ready", 64'(iss_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
